// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and feeds {Instruction, PC, Valid} into the IF/ID register.
// Optional performance counters (FetchCount, FlushCount) are built when the
// macro IF_PERF_CNT_EN is defined.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount,
`endif
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchAddr,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        Valid_id
);

    typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] hold_instr_q;
    logic        redirect;
    logic [31:0] target;

    // Branch belongs to the older instruction, so it wins over Jump.
    assign redirect = Branch | Jump;
    assign target   = (Branch ? BranchAddr : JumpAddr) & 32'hFFFF_FFFC;

    assign IMemAddr = pc_q;
    assign IMemReq  = (state_q == StFetch) & ~Stall & ~redirect & ~reset;

    // Fetch FSM, PC and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StFetch;
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            hold_instr_q   <= 32'h0;
            Instruction_id <= NOP_INSTR;
            PC_id          <= 32'h0;
            Valid_id       <= 1'b0;
        end else if (redirect) begin
            // Flush IF/ID; PC_id is left as is.
            pc_q           <= target;
            Valid_id       <= 1'b0;
            Instruction_id <= NOP_INSTR;
            unique case (state_q)
                StFetch: state_q <= StFetch;
                StWait:  state_q <= IMemValid ? StFetch : StDrop;
                StHold:  state_q <= StFetch;
                StDrop:  state_q <= IMemValid ? StFetch : StDrop;
                default: state_q <= StFetch;
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (IMemReq && IMemReady) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= StWait;
                    end
                    if (!Stall) begin
                        Valid_id       <= 1'b0;
                        Instruction_id <= NOP_INSTR;
                    end
                end
                StWait: begin
                    if (IMemValid && !Stall) begin
                        Instruction_id <= IMemRData;
                        PC_id          <= req_pc_q;
                        Valid_id       <= 1'b1;
                        state_q        <= StFetch;
                    end else if (IMemValid) begin
                        hold_instr_q <= IMemRData;
                        state_q      <= StHold;
                    end else if (!Stall) begin
                        Valid_id       <= 1'b0;
                        Instruction_id <= NOP_INSTR;
                    end
                end
                StHold: begin
                    if (!Stall) begin
                        Instruction_id <= hold_instr_q;
                        PC_id          <= req_pc_q;
                        Valid_id       <= 1'b1;
                        state_q        <= StFetch;
                    end
                end
                StDrop: begin
                    // IF/ID was flushed on entry and nothing loads here.
                    if (IMemValid) begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic deliver;
    logic discard;

    assign deliver = ~reset & ~redirect & ~Stall &
                     (((state_q == StWait) & IMemValid) | (state_q == StHold));
    // A redirect only counts when it actually throws something away.
    assign discard = ~reset & redirect &
                     (Valid_id | (state_q == StWait) | (state_q == StHold) |
                      ((state_q == StDrop) & IMemValid));

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= 32'h0;
            FlushCount <= 32'h0;
        end else begin
            if (deliver) FetchCount <= FetchCount + 32'd1;
            if (discard) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by randomized
// traffic checked against a transaction-level model (expected fetch address,
// queue of accepted requests awaiting delivery, single-outstanding memory).
module tb_if_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, Stall, Branch, Jump;
    logic [31:0] BranchAddr, JumpAddr;
    logic        IMemReq, IMemReady, IMemValid;
    logic [31:0] IMemAddr, IMemRData;
    logic [31:0] Instruction_id, PC_id;
    logic        Valid_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FetchCount, FlushCount;
`endif

    if_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef IF_PERF_CNT_EN
        .FetchCount     (FetchCount),
        .FlushCount     (FlushCount),
`endif
        .Stall          (Stall),
        .Branch         (Branch),
        .BranchAddr     (BranchAddr),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemReady      (IMemReady),
        .IMemValid      (IMemValid),
        .IMemRData      (IMemRData),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .Valid_id       (Valid_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_deliv = 0;

    // memory model state
    int          rdy_pct = 100;
    int          lat = 1;
    logic        resp_pending = 1'b0;
    logic        resp_stale = 1'b0;
    logic [31:0] resp_addr = 32'h0;
    int          resp_delay = 0;

    // reference model state
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] inflight_q[$];
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_flush = 32'h0;

    logic        obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return a * 32'h0001_0003 + 32'h0000_0013;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) return {20'hFFFFF, t[11:0]};
        return {20'h00000, t[11:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic tick();
        logic        hs, redir, rst, stl, vld, b_valid;
        logic [31:0] tgt, b_instr, b_pc, front;
        IMemValid = resp_pending && (resp_delay == 0);
        IMemRData = IMemValid ? mem(resp_addr) : $urandom;
        IMemReady = !resp_pending && ($urandom_range(0, 99) < rdy_pct);
        #1;
        obs_req  = IMemReq;
        obs_addr = IMemAddr;
        rst   = reset;
        redir = Branch | Jump;
        tgt   = (Branch ? BranchAddr : JumpAddr) & 32'hFFFF_FFFC;
        stl   = Stall;
        vld   = IMemValid;
        hs    = obs_req && IMemReady;
        if (rst || redir || stl) check("req_suppressed", obs_req, 0);
        if (obs_req) begin
            check("fetch_addr", obs_addr, exp_pc);
            check("single_outstanding", resp_pending && !resp_stale, 0);
        end
        b_valid = Valid_id;
        b_instr = Instruction_id;
        b_pc    = PC_id;
        if (!rst && redir && (b_valid || inflight_q.size() != 0 || (vld && !resp_stale)))
            exp_flush = exp_flush + 32'd1;
        @(posedge clk);
        if (vld) begin
            resp_pending = 1'b0;
            resp_stale   = 1'b0;
        end else if (resp_pending) begin
            resp_delay--;
        end
        if (hs) begin
            resp_pending = 1'b1;
            resp_stale   = 1'b0;
            resp_addr    = obs_addr;
            resp_delay   = lat - 1;
        end
        if (rst) begin
            exp_pc = RESET_PC;
            inflight_q.delete();
            if (resp_pending) resp_stale = 1'b1;
            exp_fetch = 32'h0;
            exp_flush = 32'h0;
        end else if (redir) begin
            exp_pc = tgt;
            inflight_q.delete();
        end else if (hs) begin
            exp_pc = exp_pc + 32'd4;
            inflight_q.push_back(obs_addr);
        end
        @(negedge clk);
        if (rst) begin
            check("rst_valid", Valid_id, 0);
            check("rst_instr", Instruction_id, NOP_INSTR);
            check("rst_pc_id", PC_id, 32'h0);
        end else if (redir) begin
            check("flush_valid", Valid_id, 0);
            check("flush_instr", Instruction_id, NOP_INSTR);
            check("flush_pc_hold", PC_id, b_pc);
        end else if (stl) begin
            check("stall_valid", Valid_id, b_valid);
            check("stall_instr", Instruction_id, b_instr);
            check("stall_pc", PC_id, b_pc);
        end else if (Valid_id && (!b_valid || PC_id != b_pc)) begin
            if (inflight_q.size() == 0) begin
                check("unexpected_delivery", PC_id, 32'hFFFF_FFFF);
            end else begin
                front = inflight_q.pop_front();
                check("deliv_pc", PC_id, front);
                check("deliv_instr", Instruction_id, mem(front));
            end
            n_deliv++;
            exp_fetch = exp_fetch + 32'd1;
        end
        if (!Valid_id) check("bubble_nop", Instruction_id, NOP_INSTR);
        check("inflight_bound", inflight_q.size() <= 1, 1);
`ifdef IF_PERF_CNT_EN
        check("fetch_count", FetchCount, exp_fetch);
        check("flush_count", FlushCount, exp_flush);
`endif
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0;
        BranchAddr = 32'h0; JumpAddr = 32'h0;
        IMemReady = 1'b0; IMemValid = 1'b0; IMemRData = 32'h0;
        tick(); tick();
        check("rst_req", obs_req, 0);
        reset = 1'b0;

        // Two back-to-back fetches with a zero-wait memory.
        tick(); check("a_req", obs_req, 1); check("a_addr", obs_addr, 32'h0);
        tick(); check("b_req", obs_req, 0); check("b_valid", Valid_id, 1);
        check("b_pc", PC_id, 32'h0); check("b_instr", Instruction_id, 32'h0050_0093);
        tick(); check("c_addr", obs_addr, 32'h4); check("c_bubble", Valid_id, 0);
        tick(); check("d_valid", Valid_id, 1); check("d_pc", PC_id, 32'h4);
        check("d_instr", Instruction_id, 32'h0010_0113);

        // Stall across the response for 0x8.
        tick(); check("e_addr", obs_addr, 32'h8);
        Stall = 1'b1;
        repeat (3) begin
            tick(); check("hold_req", obs_req, 0);
            check("hold_pc", PC_id, 32'h4); check("hold_valid", Valid_id, 0);
        end
        Stall = 1'b0;
        tick(); check("i_valid", Valid_id, 1); check("i_pc", PC_id, 32'h8);
        check("i_instr", Instruction_id, mem(32'h8));

        // Jump while the request is still in flight.
        lat = 3;
        tick(); check("j_addr", obs_addr, 32'hC);
        lat = 1; Jump = 1'b1; JumpAddr = 32'h103;
        tick(); check("k_req", obs_req, 0); check("k_valid", Valid_id, 0);
        Jump = 1'b0;
        tick();
        tick(); check("m_req", obs_req, 0); check("m_valid", Valid_id, 0);
        tick(); check("n_req", obs_req, 1); check("n_addr", obs_addr, 32'h100);
        tick(); check("o_pc", PC_id, 32'h100); check("o_valid", Valid_id, 1);

        // Simultaneous branch and jump: branch wins.
        Branch = 1'b1; BranchAddr = 32'h200; Jump = 1'b1; JumpAddr = 32'h300;
        tick(); check("p_req", obs_req, 0);
        Branch = 1'b0; Jump = 1'b0;
        tick(); check("q_addr", obs_addr, 32'h200);
        tick(); check("r_pc", PC_id, 32'h200);

        // Memory not ready: request held steady.
        rdy_pct = 0;
        repeat (4) begin
            tick(); check("s_req", obs_req, 1); check("s_addr", obs_addr, 32'h204);
        end
        rdy_pct = 100; lat = 3;
        tick(); check("t_addr", obs_addr, 32'h204);

        // Reset mid-WAIT; the stale response must be ignored.
        reset = 1'b1;
        tick(); check("u_req", obs_req, 0);
        reset = 1'b0; lat = 1;
        tick(); check("v_req", obs_req, 1); check("v_addr", obs_addr, RESET_PC);
        tick(); check("w_valid", Valid_id, 0);
        tick(); check("x_addr", obs_addr, RESET_PC);
        tick(); check("y_valid", Valid_id, 1); check("y_pc", PC_id, RESET_PC);
        check("y_instr", Instruction_id, 32'h0050_0093);

        // Target alignment and PC wrap-around.
        Jump = 1'b1; JumpAddr = 32'hFFFF_FFFF;
        tick();
        Jump = 1'b0;
        tick(); check("z2_addr", obs_addr, 32'hFFFF_FFFC);
        tick(); check("z3_pc", PC_id, 32'hFFFF_FFFC);
        tick(); check("z4_addr", obs_addr, 32'h0);

        // Randomized traffic.
        n_deliv = 0;
        rdy_pct = 70;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            Stall      = ($urandom_range(0, 3) == 0);
            Branch     = ($urandom_range(0, 24) == 0);
            Jump       = ($urandom_range(0, 19) == 0);
            BranchAddr = rand_tgt();
            JumpAddr   = rand_tgt();
            lat        = $urandom_range(1, 3);
            tick();
        end
        check("liveness", n_deliv >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
